multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences one instruction over 3–5 cycles (plus memory wait states), decoding the opcode from the instruction register. Every cycle it drives the datapath enables, the mux selects and the 2-bit ALUop consumed by the ALU control decoder. The unified instruction/data memory is shared, so fetch and load/store accesses stall on a ready handshake.

## Interface
Parameters:
- `COUNT_W`, 32, width of the fetch counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  instruction[31:26] from the IR; stable from DECODE until the next FETCH completes.
- `mem_ready`  in  1  memory accepted or completed the current access this cycle.
- `PCWrite`, `Branch`, `BranchNe`  out  1 each  PC write enable, beq conditional write, bne conditional write.
- `IorD`, `MemRead`, `MemWrite`, `IRWrite`  out  1 each  memory address select (1 = ALUOut), read strobe, write strobe, IR load.
- `RegDst`, `MemtoReg`, `RegWrite`, `ALUSrcA`  out  1 each  register-file and ALU-A selects.
- `ALUSrcB`  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUop`  out  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = and.
- `state`  out  4  current state, for debug.
- `illegal`  out  1  sticky unsupported-opcode flag.
- `fetch_count`  out  COUNT_W  number of completed fetches.

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, andi 001100.
- States and their assertions. Every output not listed is 0.
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. IRWrite and PCWrite equal mem_ready. Transition: to DECODE if mem_ready, otherwise stay.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUop=00. Transitions: lw/sw to MEMADR, R to RTYPE_EX, beq/bne to BRANCH, j to JUMP, addi/andi to IMM_EX, anything else to ILLEGAL.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUop=00. Transition: to MEMRD if lw, to MEMWR if sw.
- MEMRD(3): MemRead=1, IorD=1. Transition: to MEMWB if mem_ready, otherwise stay.
- MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Transition: to FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Transition: to FETCH if mem_ready, otherwise stay. MemWrite is held for the whole wait.
- RTYPE_EX(6): ALUSrcA=1, ALUSrcB=00, ALUop=10. Transition: to RTYPE_WB.
- RTYPE_WB(7): RegDst=1, MemtoReg=0, RegWrite=1. Transition: to FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSource=01. Branch=1 if beq; BranchNe=1 if bne. Transition: to FETCH.
- JUMP(9): PCSource=10, PCWrite=1. Transition: to FETCH.
- IMM_EX(10): ALUSrcA=1, ALUSrcB=10. ALUop=00 for addi, 11 for andi. Transition: to IMM_WB.
- IMM_WB(11): RegDst=0, MemtoReg=0, RegWrite=1. Transition: to FETCH.
- ILLEGAL(12): illegal=1. All enables are 0. Stays here until reset.
- Codes 13–15 are unreachable. If one is entered, the FSM goes to ILLEGAL on the next edge.
- fetch_count increments by 1 on each FETCH cycle with mem_ready=1. It wraps from 2^COUNT_W−1 to 0.

## Timing
- Outputs are Moore-decoded from `state`. The exceptions are IRWrite and PCWrite in FETCH, which are combinational on mem_ready.
- Reset behaviour: state=FETCH, illegal=0, fetch_count=0.
- While reset is high, PCWrite, IRWrite, RegWrite, MemWrite, Branch and BranchNe are forced to 0. MemRead follows FETCH (1).
- Cycles per instruction with memory always ready: lw 5, sw 4, R 4, addi/andi 4, beq/bne 3, j 3. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction returns the FSM to FETCH immediately. No partial writeback occurs after reset deasserts.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

## Test plan
- Reset with mem_ready=1, then run R-type (opcode 0) → states 0,1,6,7,0. ALUop=10 in state 6. RegWrite=1 and RegDst=1 only in state 7. fetch_count=1 after the first fetch.
- lw with mem_ready held low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 throughout state 3.
- sw, then beq, then bne → sw gives MemWrite=1 for one cycle in state 5. beq gives Branch=1, ALUop=01, PCSource=01. bne gives BranchNe=1 and Branch=0.
- addi then andi → ALUop=00 then 11 in state 10, ALUSrcB=10. j gives PCWrite=1 and PCSource=10 in state 9.
- Opcode 111111 → ILLEGAL. illegal=1, all enables 0 for 20 cycles; reset clears it.
- Assert reset during MEMWB of a lw → RegWrite=0 during reset. After release, state=0 and fetch_count=0. Separately, preload a narrow COUNT_W to force fetch_count wrap to 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS main FSM and its datapath.
// The controller drives every enable/select. The datapath supplies the
// IR opcode and the memory ready handshake.
interface multicycle_control_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               PCWrite;
  logic               Branch;
  logic               BranchNe;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic [1:0]         ALUop;
  logic [3:0]         state;
  logic               illegal;
  logic [COUNT_W-1:0] fetch_count;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop,
           state, illegal, fetch_count
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop,
           state, illegal, fetch_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences one instruction over 3-5 states. Fetch and load/store stall on
// mem_ready because the instruction/data memory is shared. All outputs are
// Moore-decoded from the state, except IRWrite/PCWrite in FETCH, which follow
// mem_ready so the IR and PC load only on the cycle the memory delivers.
module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EX   = 4'd10,
    S_IMM_WB   = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  state_t             state_q, state_d;
  logic               illegal_q;
  logic [COUNT_W-1:0] fetch_cnt_q;

  // Raw decoded controls, before the reset mask on the write enables.
  logic       pc_write, branch, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;

  // State register: async reset returns to FETCH immediately, even mid-instruction.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Sticky illegal flag: set on entry to ILLEGAL, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        illegal_q <= 1'b0;
    else if (state_d == S_ILLEGAL)    illegal_q <= 1'b1;
  end

  // Completed-fetch counter, wraps naturally at 2^COUNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   fetch_cnt_q <= '0;
    else if (state_q == S_FETCH && bus.mem_ready) fetch_cnt_q <= fetch_cnt_q + COUNT_W'(1);
  end

  // Next-state and output decode.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_op     = 2'b00;

    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed on the ALU while the memory delivers the word.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target PC + (imm << 2) into ALUOut.
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_R:             state_d = S_RTYPE_EX;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ANDI: state_d = S_IMM_EX;
          default:          state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.opcode == OP_LW)      state_d = S_MEMRD;
        else if (bus.opcode == OP_SW) state_d = S_MEMWR;
        else                          state_d = S_ILLEGAL;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        // Write strobe held for the whole wait until memory accepts it.
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        branch    = (bus.opcode == OP_BEQ);
        branch_ne = (bus.opcode == OP_BNE);
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (bus.opcode == OP_ANDI) ? 2'b11 : 2'b00;
        state_d   = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: begin
        state_d = S_ILLEGAL;
      end
      default: begin
        // Unused encodings 13-15 are only reachable by upset; park in ILLEGAL.
        state_d = S_ILLEGAL;
      end
    endcase
  end

  // Write enables are masked while reset is high so nothing is committed.
  assign bus.PCWrite     = pc_write  & ~reset;
  assign bus.IRWrite     = ir_write  & ~reset;
  assign bus.RegWrite    = reg_write & ~reset;
  assign bus.MemWrite    = mem_write & ~reset;
  assign bus.Branch      = branch    & ~reset;
  assign bus.BranchNe    = branch_ne & ~reset;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.PCSource    = pc_source;
  assign bus.ALUop       = alu_op;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.fetch_count = fetch_cnt_q;

endmodule
